// File: rtl/tiny_nn_pkg.sv
// Shared types and command encodings for the tiny_nn datapath and its command sequencer.
package tiny_nn_pkg;

    typedef logic [15:0] fp_t;

    localparam fp_t FPStdNaN = 16'h7e00;

    localparam logic [3:0] CmdOpConvolve   = 4'h1;
    localparam logic [3:0] CmdOpAccumulate = 4'h2;
    localparam logic [3:0] CmdOpTest       = 4'h3;

    localparam int unsigned CmdConvReuseBit = 11;
    localparam int unsigned CmdAccReluBit   = 8;

    typedef enum logic [3:0] {
        SeqIdle      = 4'd0,
        SeqParamIn   = 4'd1,
        SeqConvExec  = 4'd2,
        SeqConvEnd   = 4'd3,
        SeqAccBias   = 4'd4,
        SeqAccExec   = 4'd5,
        SeqAccEnd1   = 4'd6,
        SeqAccEnd2   = 4'd7,
        SeqTestCount = 4'd8,
        SeqTestPulse = 4'd9
    } seq_state_e;

    typedef enum logic [2:0] {
        OutOnes   = 3'd0,
        OutConv   = 3'd1,
        OutLow    = 3'd2,
        OutSkid   = 3'd3,
        OutDirect = 3'd4
    } out_sel_e;

endpackage

// File: rtl/tiny_nn_out_ser.sv
// Output serialiser: selects a result slice, the skid byte or a direct value onto data_o;
// the bus idles at all-ones.
module tiny_nn_out_ser
    import tiny_nn_pkg::*;
#(
    parameter int unsigned OutWidth = 8,
    parameter int unsigned PhaseW   = 1
) (
    input  logic                clk_i,
    input  out_sel_e            sel_i,
    input  logic [PhaseW-1:0]   phase_i,
    input  fp_t                 result_i,
    input  logic                skid_cap_i,
    input  logic [OutWidth-1:0] direct_i,
    output logic [OutWidth-1:0] data_o
);

    localparam int unsigned Slices = 16 / OutWidth;

    logic [7:0] skid_q;
    fp_t        shifted;

    // The skid holds the high byte so an 8-bit bus can emit it on the following beat.
    always_ff @(posedge clk_i) begin
        if (skid_cap_i) begin
            skid_q <= result_i[15:8];
        end
    end

    assign shifted = result_i >> (32'(phase_i) * OutWidth);

    always_comb begin
        data_o = '1;
        case (sel_i)
            OutConv: begin
                if (32'(phase_i) < Slices) begin
                    data_o = shifted[OutWidth-1:0];
                end
            end
            OutLow: data_o = result_i[OutWidth-1:0];
            OutSkid: begin
                if (OutWidth == 8) begin
                    data_o = OutWidth'(skid_q);
                end
            end
            OutDirect: data_o = direct_i;
            default: data_o = '1;
        endcase
    end

endmodule

// File: rtl/tiny_nn_seq.sv
// Command sequencer for tiny_nn_core: decodes the 16-bit command stream, drives the array
// control pins and serialises results onto an 8- or 16-bit output bus.
module tiny_nn_seq
    import tiny_nn_pkg::*;
#(
    parameter int unsigned ValArrayWidth  = 4,
    parameter int unsigned ValArrayHeight = 2,
    parameter int unsigned OutWidth       = 8,
    parameter int unsigned CountWidth     = 8,
    parameter int unsigned DrainCycles    = 4,
    localparam int unsigned RowSelW   = (ValArrayHeight > 1) ? $clog2(ValArrayHeight) : 1,
    localparam int unsigned NumParams = ValArrayWidth * ValArrayHeight
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [15:0]               data_i,
    output logic [OutWidth-1:0]       data_o,
    output logic                      busy_o,
    input  logic [15:0]               result_i,
    output logic [NumParams-1:0]      param_write_o,
    output logic [ValArrayHeight-1:0] val_shift_o,
    output logic [RowSelW-1:0]        mul_row_sel_o,
    output logic                      mul_en_o,
    output logic [1:0]                accumulate_en_o,
    output logic                      acc_loopback_o,
    output logic                      acc_out_relu_o,
    output logic [1:0]                acc_direct_en_o
);

    if (!(OutWidth == 8 || OutWidth == 16)) begin : g_bad_out_width
        $error("tiny_nn_seq: OutWidth must be 8 or 16");
    end
    if (ValArrayHeight < 1) begin : g_bad_height
        $error("tiny_nn_seq: ValArrayHeight must be at least 1");
    end

    seq_state_e            state_q, state_d;
    logic                  param_valid_q, param_valid_d;
    logic [NumParams-1:0]  param_write_q, param_write_d;
    logic [CountWidth-1:0] counter_q, counter_d;
    logic [CountWidth-1:0] start_count_q, start_count_d;
    logic [RowSelW-1:0]    phase_q, phase_d;
    logic                  relu_q, relu_d;

    logic                  in_conv;
    logic                  last_phase;
    logic                  is_nan;
    out_sel_e              out_sel;
    logic                  skid_cap;
    logic [OutWidth-1:0]   direct;

    assign in_conv    = (state_q == SeqConvExec) || (state_q == SeqConvEnd);
    assign last_phase = (phase_q == RowSelW'(ValArrayHeight - 1));
    assign is_nan     = (data_i == FPStdNaN);

    always_comb begin
        state_d       = state_q;
        param_valid_d = param_valid_q;
        param_write_d = param_write_q;
        counter_d     = counter_q;
        start_count_d = start_count_q;
        phase_d       = phase_q;
        relu_d        = relu_q;

        if (in_conv) begin
            phase_d = last_phase ? '0 : phase_q + 1'b1;
        end

        case (state_q)
            SeqIdle: begin
                case (data_i[15:12])
                    CmdOpConvolve: begin
                        if (data_i[CmdConvReuseBit] && param_valid_q) begin
                            state_d = SeqConvExec;
                            phase_d = '0;
                        end else begin
                            state_d       = SeqParamIn;
                            param_write_d = NumParams'(1);
                        end
                    end
                    CmdOpAccumulate: begin
                        start_count_d = data_i[CountWidth-1:0];
                        counter_d     = CountWidth'(1);
                        relu_d        = data_i[CmdAccReluBit];
                        state_d       = SeqAccBias;
                    end
                    CmdOpTest: begin
                        if (data_i[11:8] == 4'd1) begin
                            state_d   = SeqTestCount;
                            counter_d = data_i[CountWidth-1:0];
                        end else if (data_i[11:8] == 4'd0) begin
                            state_d   = SeqTestPulse;
                            counter_d = CountWidth'(1);
                        end
                    end
                    default: state_d = SeqIdle;
                endcase
            end
            SeqParamIn: begin
                param_write_d = param_write_q << 1;
                if (param_write_q[NumParams-1]) begin
                    param_valid_d = 1'b1;
                    state_d       = SeqConvExec;
                    phase_d       = '0;
                end
            end
            SeqConvExec: begin
                if (is_nan) begin
                    state_d   = SeqConvEnd;
                    counter_d = CountWidth'(DrainCycles);
                end
            end
            SeqConvEnd: begin
                if (counter_q == '0) begin
                    state_d = SeqIdle;
                end else begin
                    counter_d = counter_q - 1'b1;
                end
            end
            SeqAccBias: state_d = SeqAccExec;
            SeqAccExec: begin
                // A terminator is only honoured mid-count so the pending emit is never lost.
                if (counter_q == '0) begin
                    counter_d = start_count_q;
                end else begin
                    counter_d = counter_q - 1'b1;
                    if (is_nan) begin
                        state_d = SeqAccEnd1;
                    end
                end
            end
            SeqAccEnd1: state_d = SeqAccEnd2;
            SeqAccEnd2: state_d = SeqIdle;
            SeqTestCount: begin
                if (counter_q == '0) begin
                    state_d = SeqIdle;
                end else begin
                    counter_d = counter_q - 1'b1;
                end
            end
            SeqTestPulse: begin
                if (data_i[15:8] == 8'hf0) begin
                    counter_d = counter_q - 1'b1;
                end else begin
                    state_d = SeqIdle;
                end
            end
            default: state_d = SeqIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= SeqIdle;
            param_valid_q <= 1'b0;
            param_write_q <= '0;
        end else begin
            state_q       <= state_d;
            param_valid_q <= param_valid_d;
            param_write_q <= param_write_d;
        end
    end

    always_ff @(posedge clk_i) begin
        counter_q     <= counter_d;
        start_count_q <= start_count_d;
        phase_q       <= phase_d;
        relu_q        <= relu_d;
    end

    // Core controls decode purely from registered state, so reset clears them at once.
    always_comb begin
        val_shift_o     = '0;
        mul_row_sel_o   = '0;
        mul_en_o        = 1'b0;
        accumulate_en_o = 2'b00;
        acc_loopback_o  = 1'b0;
        acc_out_relu_o  = 1'b0;
        acc_direct_en_o = 2'b00;
        out_sel         = OutOnes;
        skid_cap        = 1'b0;
        direct          = '0;

        case (state_q)
            SeqConvExec, SeqConvEnd: begin
                val_shift_o     = ValArrayHeight'(1) << phase_q;
                mul_row_sel_o   = phase_q;
                mul_en_o        = 1'b1;
                accumulate_en_o = {last_phase, 1'b1};
                out_sel         = OutConv;
            end
            SeqAccBias: acc_direct_en_o = 2'b10;
            SeqAccExec: begin
                accumulate_en_o = 2'b10;
                acc_direct_en_o = 2'b01;
                if (counter_q == '0) begin
                    out_sel  = OutLow;
                    skid_cap = 1'b1;
                end else begin
                    acc_loopback_o = 1'b1;
                    acc_out_relu_o = relu_q && (counter_q == CountWidth'(1));
                    out_sel        = OutSkid;
                end
            end
            SeqAccEnd1: begin
                out_sel  = OutLow;
                skid_cap = 1'b1;
            end
            SeqAccEnd2: out_sel = OutSkid;
            SeqTestCount: begin
                out_sel = OutDirect;
                direct  = OutWidth'(counter_q);
            end
            SeqTestPulse: begin
                out_sel = OutDirect;
                direct  = counter_q[0] ? {(OutWidth/2){2'b10}} : {(OutWidth/2){2'b01}};
            end
            default: out_sel = OutOnes;
        endcase
    end

    assign busy_o        = (state_q != SeqIdle);
    assign param_write_o = param_write_q;

    tiny_nn_out_ser #(
        .OutWidth (OutWidth),
        .PhaseW   (RowSelW)
    ) u_out_ser (
        .clk_i      (clk_i),
        .sel_i      (out_sel),
        .phase_i    (phase_q),
        .result_i   (result_i),
        .skid_cap_i (skid_cap),
        .direct_i   (direct),
        .data_o     (data_o)
    );

endmodule

// File: tb/tb_tiny_nn_seq.sv
// Directed bench for tiny_nn_seq: default build, a 16-bit output build and a four-row build.
module tb_tiny_nn_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] data_a, data_h, result;

    logic [7:0]  a_data;  logic a_busy; logic [7:0]  a_pw; logic [1:0] a_vs; logic [0:0] a_rs;
    logic a_mul; logic [1:0] a_acc; logic a_lb; logic a_relu; logic [1:0] a_dir;
    logic [15:0] w_data;  logic w_busy; logic [7:0]  w_pw; logic [1:0] w_vs; logic [0:0] w_rs;
    logic w_mul; logic [1:0] w_acc; logic w_lb; logic w_relu; logic [1:0] w_dir;
    logic [7:0]  h_data;  logic h_busy; logic [15:0] h_pw; logic [3:0] h_vs; logic [1:0] h_rs;
    logic h_mul; logic [1:0] h_acc; logic h_lb; logic h_relu; logic [1:0] h_dir;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    tiny_nn_seq u_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_a), .data_o(a_data), .busy_o(a_busy),
        .result_i(result), .param_write_o(a_pw), .val_shift_o(a_vs), .mul_row_sel_o(a_rs),
        .mul_en_o(a_mul), .accumulate_en_o(a_acc), .acc_loopback_o(a_lb),
        .acc_out_relu_o(a_relu), .acc_direct_en_o(a_dir)
    );

    tiny_nn_seq #(.OutWidth(16)) u_w (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_a), .data_o(w_data), .busy_o(w_busy),
        .result_i(result), .param_write_o(w_pw), .val_shift_o(w_vs), .mul_row_sel_o(w_rs),
        .mul_en_o(w_mul), .accumulate_en_o(w_acc), .acc_loopback_o(w_lb),
        .acc_out_relu_o(w_relu), .acc_direct_en_o(w_dir)
    );

    tiny_nn_seq #(.ValArrayHeight(4)) u_h (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_h), .data_o(h_data), .busy_o(h_busy),
        .result_i(result), .param_write_o(h_pw), .val_shift_o(h_vs), .mul_row_sel_o(h_rs),
        .mul_en_o(h_mul), .accumulate_en_o(h_acc), .acc_loopback_o(h_lb),
        .acc_out_relu_o(h_relu), .acc_direct_en_o(h_dir)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input int which);
        int n = 0;
        while (((which == 0) ? a_busy : h_busy) && n < 64) begin
            cyc();
            n++;
        end
        chk("idle_wait", 32'((which == 0) ? a_busy : h_busy), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ph;
        rst_ni = 1'b0;
        data_a = '0;
        data_h = '0;
        result = '0;
        #2;
        // reset state of every output of all three builds
        chk("rst_a_data", 32'(a_data), 32'hff);   chk("rst_w_data", 32'(w_data), 32'hffff);
        chk("rst_h_data", 32'(h_data), 32'hff);
        chk("rst_busy", 32'({a_busy, w_busy, h_busy}), 32'(0));
        chk("rst_pw", 32'({a_pw, w_pw, h_pw}), 32'(0));
        chk("rst_vs", 32'({a_vs, w_vs, h_vs}), 32'(0));
        chk("rst_rs", 32'({a_rs, w_rs, h_rs}), 32'(0));
        chk("rst_mul", 32'({a_mul, w_mul, h_mul}), 32'(0));
        chk("rst_acc", 32'({a_acc, w_acc, h_acc}), 32'(0));
        chk("rst_lb", 32'({a_lb, w_lb, h_lb, a_relu, w_relu, h_relu}), 32'(0));
        chk("rst_dir", 32'({a_dir, w_dir, h_dir}), 32'(0));
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        cyc();

        // convolve with full parameter load
        data_a = 16'h1000; #2;
        chk("conv_cmd_busy", 32'(a_busy), 32'(0));
        cyc();
        for (int i = 0; i < 8; i++) begin
            data_a = 16'h4000 + 16'(i); #2;
            chk("conv_pw", 32'(a_pw), 32'(1) << i);
            chk("conv_pw_busy", 32'(a_busy), 32'(1));
            chk("conv_pw_mul", 32'(a_mul), 32'(0));
            cyc();
        end
        for (int j = 0; j < 3; j++) begin
            data_a = 16'h3c00;
            result = 16'ha1b0 + 16'(j) * 16'h0101; #2;
            ph = j % 2;
            chk("conv_vs", 32'(a_vs), (ph == 1) ? 32'h2 : 32'h1);
            chk("conv_rs", 32'(a_rs), 32'(ph));
            chk("conv_acc", 32'(a_acc), (ph == 1) ? 32'h3 : 32'h1);
            chk("conv_data", 32'(a_data), (ph == 1) ? 32'(result[15:8]) : 32'(result[7:0]));
            chk("conv_w_data", 32'(w_data), (ph == 1) ? 32'hffff : 32'(result));
            chk("conv_pw_clear", 32'(a_pw), 32'(0));
            cyc();
        end
        data_a = 16'h7e00; #2;
        chk("conv_nan_vs", 32'(a_vs), 32'h2);
        cyc();
        data_a = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("conv_drain_busy", 32'(a_busy), 32'(1));
            chk("conv_drain_vs", 32'(a_vs), (k % 2 == 1) ? 32'h2 : 32'h1);
            cyc();
        end
        #2;
        chk("conv_done_busy", 32'(a_busy), 32'(0));
        chk("conv_done_mul", 32'(a_mul), 32'(0));
        chk("conv_done_data", 32'(a_data), 32'hff);
        cyc();

        // parameter reuse, then reset mid-convolve
        data_a = 16'h1800; #2;
        cyc();
        data_a = 16'h3c00; #2;
        chk("reuse_vs", 32'(a_vs), 32'h1);
        chk("reuse_mul", 32'(a_mul), 32'(1));
        chk("reuse_pw", 32'(a_pw), 32'(0));
        cyc();
        #2;
        chk("reuse_vs2", 32'(a_vs), 32'h2);
        rst_ni = 1'b0; #1;
        chk("midrst_busy", 32'({a_busy, w_busy}), 32'(0));
        chk("midrst_ctrl", 32'({a_mul, a_vs, a_acc, a_dir}), 32'(0));
        chk("midrst_data", 32'(a_data), 32'hff);
        rst_ni = 1'b1;
        cyc();
        data_a = 16'h1800; #2;
        cyc();
        data_a = 16'h4000; #2;
        chk("rst_reload_pw", 32'(a_pw), 32'h1);
        chk("rst_reload_mul", 32'(a_mul), 32'(0));
        for (int i = 1; i < 8; i++) begin
            cyc(); #2;
            chk("rst_reload_pw", 32'(a_pw), 32'(1) << i);
        end
        cyc();
        data_a = 16'h7e00; #2;
        chk("rst_reload_exec", 32'(a_mul), 32'(1));
        cyc();
        data_a = 16'h0000;
        wait_idle(0);
        cyc();

        // accumulate: count 2, relu on
        data_a = 16'h2102; #2;
        cyc();
        data_a = 16'h3c00; #2;
        chk("acc_bias_dir", 32'(a_dir), 32'h2);
        chk("acc_bias_acc", 32'(a_acc), 32'h0);
        cyc();
        data_a = 16'h4000; result = 16'h1234; #2;
        chk("acc_c1_dir", 32'(a_dir), 32'h1);
        chk("acc_c1_acc", 32'(a_acc), 32'h2);
        chk("acc_c1_lb", 32'(a_lb), 32'(1));
        chk("acc_c1_relu", 32'(a_relu), 32'(1));
        cyc();
        result = 16'h5678; #2;
        chk("acc_emit_lo", 32'(a_data), 32'h78);
        chk("acc_emit_w", 32'(w_data), 32'h5678);
        chk("acc_emit_lb", 32'({a_lb, a_relu}), 32'(0));
        cyc();
        result = 16'h9abc; #2;
        chk("acc_skid", 32'(a_data), 32'h56);
        chk("acc_skid_w", 32'(w_data), 32'hffff);
        chk("acc_c2_relu", 32'({a_lb, a_relu}), 32'h2);
        cyc();
        data_a = 16'h7e00; result = 16'hdef0; #2;
        chk("acc_c1b_relu", 32'({a_lb, a_relu}), 32'h3);
        chk("acc_c1b_data", 32'(a_data), 32'h56);
        cyc();
        data_a = 16'h0000; result = 16'h1357; #2;
        chk("acc_end1_data", 32'(a_data), 32'h57);
        chk("acc_end1_w", 32'(w_data), 32'h1357);
        chk("acc_end1_ctrl", 32'({a_dir, a_acc}), 32'(0));
        cyc();
        result = 16'hffff; #2;
        chk("acc_end2_data", 32'(a_data), 32'h13);
        chk("acc_end2_busy", 32'(a_busy), 32'(1));
        cyc();
        #2;
        chk("acc_idle", 32'(a_busy), 32'(0));
        chk("acc_idle_data", 32'(a_data), 32'hff);

        // test count
        data_a = 16'h3105; #2;
        cyc();
        data_a = 16'h0000;
        for (int k = 5; k >= 0; k--) begin
            #2;
            chk("tcount", 32'(a_data), 32'(k));
            chk("tcount_w", 32'(w_data), 32'(k));
            cyc();
        end
        #2;
        chk("tcount_idle", 32'(a_busy), 32'(0));

        // test pulse
        data_a = 16'h3000; #2;
        cyc();
        data_a = 16'hf000; #2;
        chk("tpulse_odd", 32'(a_data), 32'haa);
        chk("tpulse_odd_w", 32'(w_data), 32'haaaa);
        cyc();
        data_a = 16'h0000; #2;
        chk("tpulse_even", 32'(a_data), 32'h55);
        chk("tpulse_even_w", 32'(w_data), 32'h5555);
        cyc();
        #2;
        chk("tpulse_idle", 32'(a_busy), 32'(0));

        // unrecognised test sub-command stays idle
        data_a = 16'h3200; #2;
        cyc();
        data_a = 16'h0000; #2;
        chk("tbad_idle", 32'(a_busy), 32'(0));
        cyc();

        // four-row build convolve
        data_h = 16'h1000; #2;
        cyc();
        for (int i = 0; i < 16; i++) begin
            data_h = 16'h4000; #2;
            chk("h4_pw", 32'(h_pw), 32'(1) << i);
            cyc();
        end
        for (int j = 0; j < 6; j++) begin
            data_h = 16'h3c00;
            result = 16'hc3d2 + 16'(j); #2;
            ph = j % 4;
            chk("h4_vs", 32'(h_vs), 32'(1) << ph);
            chk("h4_rs", 32'(h_rs), 32'(ph));
            chk("h4_acc1", 32'(h_acc[1]), 32'(ph == 3));
            chk("h4_data", 32'(h_data), (ph == 0) ? 32'(result[7:0]) :
                                        (ph == 1) ? 32'(result[15:8]) : 32'hff);
            cyc();
        end
        data_h = 16'h7e00;
        cyc();
        data_h = 16'h0000;
        wait_idle(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
